ntt_ctrl: RTL and testbench
===========================

// Module: ntt_ctrl
// PURPOSE
//  Sequencer driving the butterfly datapath through a full 256-point NTT (CT, forward) or
//  INTT (GS, inverse) for Dilithium or Kyber. Generates coefficient-RAM read/write address
//  pairs, twiddle-ROM index and butterfly selects. Inserts drain gaps between layers so no
//  read overtakes a pending write. Final n^-1 scaling is out of scope.
// PARAMETERS
//  RD_LAT  1  read latency (cycles) of coefficient RAM and twiddle ROM, >=1
//  BF_LAT  0  butterfly pipeline depth (0 = combinational)
// PORTS
//  clk_i            in   1  clock, rising edge
//  rst_n_i          in   1  asynchronous active-low reset
//  start_i          in   1  start pulse; sampled only in IDLE
//  mode_i           in   1  0 forward NTT (Cooley-Tukey), 1 inverse (Gentleman-Sande)
//  sel_red_i        in   1  0 Dilithium (8 layers, len 128..1), 1 Kyber (7 layers, len 128..2)
//  rd_en_o          out  1  read strobe, RAM ports A/B and twiddle ROM
//  rd_addr_a_o      out  8  read address, operand a
//  rd_addr_b_o      out  8  read address, operand b
//  twiddle_idx_o    out  8  twiddle ROM index, same cycle as rd_addr_*
//  sel_butterfly_o  out  1  to butterfly: = mode latched at start
//  sel_red_o        out  1  to butterfly: = sel_red latched at start
//  wr_en_o          out  1  write strobe for butterfly results
//  wr_addr_a_o      out  8  write address for a_o
//  wr_addr_b_o      out  8  write address for b_o
//  busy_o           out  1  high from cycle after accepted start until done_o
//  done_o           out  1  one-cycle pulse, transform complete
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. Async assert clears wr_en_o/rd_en_o at once.
//  FSM: IDLE -start_i-> RUN; RUN -j==127-> DRAIN; DRAIN -LAT cycles-> RUN (next layer) or DONE
//   (last layer); DONE -1 cycle, done_o=1-> IDLE. LAT = RD_LAT+BF_LAT.
//  mode_i/sel_red_i latched on accepted start; start_i ignored while busy_o=1.
//  Layer order: forward len=128,64,..,Lmin; inverse len=Lmin,..,128; Lmin=1 Dil, 2 Kyber.
//  RUN: one butterfly issued per cycle, j=0..127 per layer; len=2^s:
//   g=j>>s, o=j&(len-1); addr_a=2*len*g+o; addr_b=addr_a+len (8-bit, never wraps).
//   twiddle forward: 128/len+g; inverse: 256/len-1-g.
//  Write path: {addr_a,addr_b,valid} shift register depth LAT; wr_en_o/wr_addr_* exactly LAT
//   cycles after the matching rd_en_o. rd_en_o=0 in DRAIN, DONE, IDLE.
//  DRAIN lasts LAT cycles: next layer's first read is cycle after previous layer's last write.
//  Total: start accepted at cycle 0, first rd_en_o at cycle 1; done_o at cycle
//   1+layers*(128+LAT); Dil LAT=1: 1033, Kyber LAT=1: 904.
//  Reset mid-operation: abort, return IDLE, no done_o; pending writes discarded.
// TESTING
//  Dil fwd, LAT=1: first issue (0,128) tw 1; j=127 (127,255) tw 1; wr same pair 1 cycle later.
//  Dil fwd layer len=64, j=64 -> (128,192) tw 3; layer len=1, j=127 -> (254,255) tw 255.
//  Kyber fwd: 7 layers; last layer j=0 (0,2) tw 64, j=127 (253,255) tw 127; done_o @904.
//  Dil inv: first layer j=0 (0,1) tw 255; last layer len=128 tw 1; sel_butterfly_o=1.
//  RD_LAT=2,BF_LAT=1: wr_en_o 3 cycles after rd_en_o; 3-cycle gap between layers; done @1049.
//  start_i pulsed while busy ignored; rst_n_i low mid-layer -> outputs 0 immediately, no done_o.

Source files
------------

// File: rtl/ntt_ctrl.sv
// Address/twiddle sequencer for a 256-point NTT/INTT butterfly datapath (Dilithium/Kyber).
// Issues one butterfly per cycle and drains the RAM/butterfly pipeline between layers.
module ntt_ctrl #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       sel_red_i,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [7:0] twiddle_idx_o,
    output logic       sel_butterfly_o,
    output logic       sel_red_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned LAT   = RD_LAT + BF_LAT;
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [6:0]       j_q, j_d;
    logic [2:0]       layer_q, layer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       accept, mode_d, red_d, last_layer;
    logic [2:0] shift;
    logic [7:0] len, g, o, addr_a, addr_b, tw;
    logic       rd_en_d, busy_d, done_d;
    logic [7:0] rd_a_d, rd_b_d, tw_d;

    logic       pipe_v [LAT];
    logic [7:0] pipe_a [LAT];
    logic [7:0] pipe_b [LAT];

    // Mode/reduction selects are captured on the accepting edge and held in the output flops.
    always_comb begin
        accept     = (state_q == S_IDLE) && start_i;
        mode_d     = accept ? mode_i    : sel_butterfly_o;
        red_d      = accept ? sel_red_i : sel_red_o;
        last_layer = (layer_q == (sel_red_o ? 3'd6 : 3'd7));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            layer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    j_d     = '0;
                    layer_d = '0;
                end
            end
            S_RUN: begin
                j_d = j_q + 7'd1;
                if (j_q == 7'd127) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    if (last_layer) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        layer_d = layer_q + 3'd1;
                        j_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        shift   = mode_d ? (layer_d + {2'b00, red_d}) : (3'd7 - layer_d);
        len     = 8'd1 << shift;
        g       = {1'b0, j_d} >> shift;
        o       = {1'b0, j_d} & (len - 8'd1);
        addr_a  = (g << (4'(shift) + 4'd1)) | o;
        addr_b  = addr_a + len;
        tw      = mode_d ? 8'((9'd256 >> shift) - 9'd1 - {1'b0, g})
                         : ((8'd128 >> shift) + g);
        rd_en_d = (state_d == S_RUN);
        rd_a_d  = rd_en_d ? addr_a : 8'd0;
        rd_b_d  = rd_en_d ? addr_b : 8'd0;
        tw_d    = rd_en_d ? tw     : 8'd0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_en_o         <= 1'b0;
            rd_addr_a_o     <= '0;
            rd_addr_b_o     <= '0;
            twiddle_idx_o   <= '0;
            sel_butterfly_o <= 1'b0;
            sel_red_o       <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            rd_en_o         <= rd_en_d;
            rd_addr_a_o     <= rd_a_d;
            rd_addr_b_o     <= rd_b_d;
            twiddle_idx_o   <= tw_d;
            sel_butterfly_o <= mode_d;
            sel_red_o       <= red_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
        end
    end

    // Write-address delay line matching the RAM read plus butterfly latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_en_o;
            pipe_a[0] <= rd_addr_a_o;
            pipe_b[0] <= rd_addr_b_o;
            for (int i = 1; i < int'(LAT); i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign wr_en_o     = pipe_v[LAT-1];
    assign wr_addr_a_o = pipe_a[LAT-1];
    assign wr_addr_b_o = pipe_b[LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: two instances (LAT=1 and LAT=3) checked every cycle against a
// timeline model of the transform, plus directed literal checks at key cycles.
module tb_ntt_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      start, mode, red;
    logic [1:0]      rd_en, wr_en, sb, sr, busy, done;
    logic [1:0][7:0] ra, rb, tw, wa, wb;

    ntt_ctrl u_lat1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[0]), .mode_i(mode[0]), .sel_red_i(red[0]),
        .rd_en_o(rd_en[0]), .rd_addr_a_o(ra[0]), .rd_addr_b_o(rb[0]), .twiddle_idx_o(tw[0]),
        .sel_butterfly_o(sb[0]), .sel_red_o(sr[0]), .wr_en_o(wr_en[0]),
        .wr_addr_a_o(wa[0]), .wr_addr_b_o(wb[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    ntt_ctrl #(.RD_LAT(2), .BF_LAT(1)) u_lat3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[1]), .mode_i(mode[1]), .sel_red_i(red[1]),
        .rd_en_o(rd_en[1]), .rd_addr_a_o(ra[1]), .rd_addr_b_o(rb[1]), .twiddle_idx_o(tw[1]),
        .sel_butterfly_o(sb[1]), .sel_red_o(sr[1]), .wr_en_o(wr_en[1]),
        .wr_addr_a_o(wa[1]), .wr_addr_b_o(wb[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    typedef struct packed {
        logic       rd;
        logic [7:0] ra, rb, tw;
        logic       wr;
        logic [7:0] wa, wb;
        logic       sb, sr, busy, done;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;
    int cur_t = 0;
    int done_cnt0 = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Butterfly pair and twiddle for layer ly (0 = first processed), index j.
    function automatic void pair(input int ly, input int j, input bit md, input bit kyb,
                                 output int a, output int b, output int w);
        int len, g, o;
        len = md ? ((kyb ? 2 : 1) << ly) : (128 >> ly);
        g   = j / len;
        o   = j % len;
        a   = 2 * len * g + o;
        b   = a + len;
        w   = md ? (256 / len - 1 - g) : (128 / len + g);
    endfunction

    function automatic int done_time(input int lat, input bit kyb);
        return 1 + (kyb ? 7 : 8) * (128 + lat);
    endfunction

    // Expected outputs at t cycles after the accepting cycle.
    function automatic obs_t model(input bit act, input int t, input int lat, input bit md,
                                   input bit kyb, input bit lsb, input bit lsr);
        obs_t e;
        int per, dt, k, ly, w, a, b, x;
        e    = '0;
        e.sb = lsb;
        e.sr = lsr;
        if (act) begin
            per    = 128 + lat;
            dt     = done_time(lat, kyb);
            e.busy = (t >= 1 && t <= dt);
            e.done = (t == dt);
            if (t >= 1 && t < dt) begin
                k  = t - 1;
                ly = k / per;
                w  = k % per;
                if (w < 128) begin
                    pair(ly, w, md, kyb, a, b, x);
                    e.rd = 1'b1; e.ra = 8'(a); e.rb = 8'(b); e.tw = 8'(x);
                end
                if (w >= lat && (w - lat) < 128) begin
                    pair(ly, w - lat, md, kyb, a, b, x);
                    e.wr = 1'b1; e.wa = 8'(a); e.wb = 8'(b);
                end
            end
        end
        return e;
    endfunction

    bit   act [2];
    int   tt  [2];
    bit   lmd [2];
    bit   lkb [2];
    obs_t e_o, a_o;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0; lmd[i] = 1'b0; lkb[i] = 1'b0;
            end else if (act[i]) begin
                tt[i]++;
                if (tt[i] > done_time(lat_of(i), lkb[i])) act[i] = 1'b0;
            end
            e_o = model(act[i], tt[i], lat_of(i), lmd[i], lkb[i], lmd[i], lkb[i]);
            a_o = {rd_en[i], ra[i], rb[i], tw[i], wr_en[i], wa[i], wb[i],
                   sb[i], sr[i], busy[i], done[i]};
            vectors++;
            if (a_o !== e_o) begin
                miscompares++;
                if (miscompares < 30)
                    $display("FAIL cycle_model dut%0d t=%0d got %h expected %h", i, tt[i], a_o, e_o);
            end
            if (rst_n && !act[i] && start[i]) begin
                act[i] = 1'b1; tt[i] = 0; lmd[i] = mode[i]; lkb[i] = red[i];
            end
        end
        if (done[0]) done_cnt0++;
    end

    task automatic chk(input string nm, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", nm, actual, expected);
        end
    endtask

    task automatic run(input int i, input bit m, input bit k);
        @(posedge clk); #1;
        start[i] = 1'b1; mode[i] = m; red[i] = k;
        @(posedge clk); #1;
        start[i] = 1'b0;
        cur_t = 1;
    endtask

    task automatic goto_t(input int n);
        repeat (n - cur_t) @(posedge clk);
        #2;
        cur_t = n;
    endtask

    initial begin
        rst_n = 1'b0; start = '0; mode = '0; red = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_outputs", int'({rd_en, wr_en, busy, done, sb, sr}), 0);

        // Dilithium forward, LAT=1
        run(0, 1'b0, 1'b0);
        goto_t(1);
        chk("dil_fwd_first_ra", int'(ra[0]), 0);
        chk("dil_fwd_first_rb", int'(rb[0]), 128);
        chk("dil_fwd_first_tw", int'(tw[0]), 1);
        chk("dil_fwd_busy", int'(busy[0]), 1);
        goto_t(2);
        chk("dil_fwd_first_wr", int'({wr_en[0], wa[0], wb[0]}), int'({1'b1, 8'd0, 8'd128}));
        goto_t(128);
        chk("dil_fwd_j127", int'({ra[0], rb[0], tw[0]}), int'({8'd127, 8'd255, 8'd1}));
        goto_t(129);
        chk("dil_fwd_drain_rd", int'(rd_en[0]), 0);
        chk("dil_fwd_j127_wr", int'({wr_en[0], wa[0], wb[0]}), int'({1'b1, 8'd127, 8'd255}));
        goto_t(194);
        chk("dil_fwd_len64_j64", int'({ra[0], rb[0], tw[0]}), int'({8'd128, 8'd192, 8'd3}));
        start[0] = 1'b1; mode[0] = 1'b1;
        goto_t(195);
        start[0] = 1'b0; mode[0] = 1'b0;
        chk("start_ignored_sel", int'(sb[0]), 0);
        goto_t(1031);
        chk("dil_fwd_len1_j127", int'({ra[0], rb[0], tw[0]}), int'({8'd254, 8'd255, 8'd255}));
        goto_t(1033);
        chk("dil_fwd_done", int'({busy[0], done[0]}), 3);
        goto_t(1034);
        chk("dil_fwd_after_done", int'({busy[0], done[0]}), 0);

        // Kyber forward, LAT=1
        run(0, 1'b0, 1'b1);
        goto_t(1);
        chk("kyb_fwd_sel_red", int'(sr[0]), 1);
        goto_t(775);
        chk("kyb_fwd_last_j0", int'({ra[0], rb[0], tw[0]}), int'({8'd0, 8'd2, 8'd64}));
        goto_t(902);
        chk("kyb_fwd_last_j127", int'({ra[0], rb[0], tw[0]}), int'({8'd253, 8'd255, 8'd127}));
        goto_t(904);
        chk("kyb_fwd_done", int'(done[0]), 1);
        goto_t(905);

        // Dilithium inverse, LAT=1
        run(0, 1'b1, 1'b0);
        goto_t(1);
        chk("dil_inv_first", int'({ra[0], rb[0], tw[0]}), int'({8'd0, 8'd1, 8'd255}));
        chk("dil_inv_sel_bf", int'(sb[0]), 1);
        goto_t(904);
        chk("dil_inv_len128", int'({ra[0], rb[0], tw[0]}), int'({8'd0, 8'd128, 8'd1}));
        goto_t(1033);
        chk("dil_inv_done", int'(done[0]), 1);
        goto_t(1034);

        // Dilithium forward, RD_LAT=2 BF_LAT=1
        run(1, 1'b0, 1'b0);
        goto_t(1);
        chk("lat3_first_rd", int'({rd_en[1], ra[1], rb[1]}), int'({1'b1, 8'd0, 8'd128}));
        goto_t(3);
        chk("lat3_no_wr_yet", int'(wr_en[1]), 0);
        goto_t(4);
        chk("lat3_first_wr", int'({wr_en[1], wa[1], wb[1]}), int'({1'b1, 8'd0, 8'd128}));
        goto_t(131);
        chk("lat3_gap_rd", int'(rd_en[1]), 0);
        chk("lat3_last_wr", int'({wr_en[1], wa[1], wb[1]}), int'({1'b1, 8'd127, 8'd255}));
        goto_t(132);
        chk("lat3_layer2_first", int'({rd_en[1], ra[1], rb[1], tw[1]}),
            int'({1'b1, 8'd0, 8'd64, 8'd2}));
        goto_t(1049);
        chk("lat3_done", int'(done[1]), 1);
        goto_t(1050);

        // Reset mid-layer on Kyber inverse
        run(0, 1'b1, 1'b1);
        goto_t(300);
        chk("abort_busy_before", int'(busy[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", int'({rd_en[0], wr_en[0], busy[0], done[0]}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (1200) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt0, 3);
        chk("abort_idle", int'(busy[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
